target_manager: RTL and testbench
=================================

// Module: target_manager
// PURPOSE
//   Owns the food target. Compares the snake head with the target on each game step
//   and emits a one-CLK REACHED_TARGET pulse, which feeds the score counter directly.
//   Then places a new target at a pseudo-random free cell, using an occupancy query to the snake body store.
// PARAMETERS
//   GRID_W     40        playfield width in cells (x range 0..GRID_W-1)
//   GRID_H     30        playfield height in cells (y range 0..GRID_H-1)
//   COORD_W    6         coordinate width; 2**COORD_W >= max(GRID_W,GRID_H)
//   LFSR_SEED  16'hACE1  LFSR reset value; must be non-zero
//   MAX_TRIES  16        random candidates rejected before switching to raster scan
// PORTS
//   CLK             in   1        system clock; all logic on posedge CLK
//   RESET           in   1        synchronous, active-high reset
//   GAME_TICK       in   1        one-CLK pulse per game step (already synchronised to CLK)
//   HEAD_X          in   COORD_W  snake head x, stable when GAME_TICK=1
//   HEAD_Y          in   COORD_W  snake head y
//   OCC_REQ         out  1        one-CLK occupancy query strobe
//   OCC_X, OCC_Y    out  COORD_W  queried cell; held stable until OCC_VALID
//   OCC_VALID       in   1        one-CLK answer strobe, any latency >=1 after OCC_REQ
//   OCC_HIT         in   1        1 = queried cell holds snake body; sampled with OCC_VALID
//   TARGET_X/Y      out  COORD_W  current target cell
//   TARGET_VALID    out  1        target displayed and hit-testable
//   REACHED_TARGET  out  1        one-CLK pulse on head==target
//   BOARD_FULL      out  1        no free cell found; sticky until RESET
// BEHAVIOUR
//   Reset (RESET=1 at posedge, overrides everything):
//   - state=IDLE, LFSR=LFSR_SEED, TARGET_X=GRID_W-8, TARGET_Y=GRID_H/2, TARGET_VALID=1.
//   - REACHED_TARGET=0, OCC_REQ=0, OCC_X/Y=0, BOARD_FULL=0, try count=0.
//   - Reset mid-search abandons the search. Late OCC_VALID after reset is ignored.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs one step every CLK, not only on ticks.
//   States: IDLE, GEN, WAIT_RND, SCAN, WAIT_SCAN, FULL.
//   - IDLE: on GAME_TICK with TARGET_VALID and HEAD==TARGET:
//     REACHED_TARGET=1 the next cycle (exactly one CLK), TARGET_VALID<=0, tries<=0, ->GEN.
//     Miss, or no GAME_TICK: stay in IDLE.
//   - GEN: candidate x=LFSR[COORD_W-1:0], y=LFSR[2*COORD_W-1:COORD_W].
//     Candidate out of range (x>=GRID_W or y>=GRID_H): discard, stay GEN; does not count as a try.
//     Candidate in range: drive OCC_X/Y, OCC_REQ=1 for one CLK, ->WAIT_RND.
//   - WAIT_RND: on OCC_VALID:
//     OCC_HIT=0 and candidate!=HEAD: commit TARGET_X/Y, TARGET_VALID<=1, ->IDLE.
//     Otherwise tries++; tries reaching MAX_TRIES -> SCAN starting at the candidate; else ->GEN.
//   - SCAN/WAIT_SCAN: raster walk x+1; x wraps GRID_W-1 -> 0 with y+1; y wraps GRID_H-1 -> 0.
//     One OCC_REQ per cell; free cell -> commit as above.
//     Return to the scan start with no free cell -> BOARD_FULL<=1, ->FULL.
//   - FULL: terminal; TARGET_VALID=0; only RESET leaves FULL.
//   GAME_TICK is ignored outside IDLE: no hit test runs while TARGET_VALID=0.
//   Worst case: one REACHED_TARGET per found target.
//   OCC_VALID outside WAIT_* states is ignored.
//   Latency: GAME_TICK hit -> REACHED_TARGET 1 CLK; new target >= 3 CLK after the pulse.
//   Equality compare uses full COORD_W bits; no arithmetic wraps beyond the GRID bounds.
// STRUCTURE
//   Shared package snake_pkg:
//   - GRID_W, GRID_H, COORD_W constants;
//   - coord_t typedef (logic [COORD_W-1:0]);
//   - tgt_state_t enum.
//   Sub-module target_lfsr: 16-bit LFSR with seed parameter, enable tied high.
//   FSM, try counter and scan pointer stay in target_manager.
// TESTING
//   1. Reset, then GAME_TICK with HEAD=(32,15) -> REACHED_TARGET one CLK later, width 1;
//      TARGET_VALID=0.
//   2. After a hit, responder answers OCC_HIT=0 at 2-CLK latency -> TARGET_VALID=1 within 10 CLK;
//      target in range and != head.
//   3. Responder answers OCC_HIT=1 sixteen times -> SCAN entered;
//      first free cell in raster order after the start cell becomes the target.
//   4. Responder always answers OCC_HIT=1 -> BOARD_FULL=1 after GRID_W*GRID_H scan queries;
//      GAME_TICK produces no pulse.
//   5. RESET asserted while in WAIT_RND, with OCC_VALID arriving 1 CLK later ->
//      outputs return to reset values; late OCC_VALID ignored.
//   6. GAME_TICK with head!=target, and GAME_TICK during GEN -> no REACHED_TARGET;
//      score-counter stub counts exactly one per hit.

Source files
------------

// File: rtl/snake_pkg.sv
// Playfield constants, coordinate/cell types, target FSM states and the raster-step helper.
package snake_pkg;
  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int COORD_W = 6;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_WAIT_RND,
    ST_SCAN,
    ST_WAIT_SCAN,
    ST_FULL
  } tgt_state_t;

  // Next cell in raster order; wraps right edge to next row and bottom row to the top.
  function automatic cell_t raster_next(input cell_t c);
    cell_t n;
    n = c;
    if (c.x == coord_t'(GRID_W - 1)) begin
      n.x = '0;
      n.y = (c.y == coord_t'(GRID_H - 1)) ? '0 : c.y + 1'b1;
    end else begin
      n.x = c.x + 1'b1;
    end
    return n;
  endfunction
endpackage

// File: rtl/target_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the low bits used as x/y candidates.
module target_lfsr
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [2*COORD_W-1:0] rnd
);
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign rnd = lfsr[2*COORD_W-1:0];
endmodule

// File: rtl/target_manager.sv
// Food target owner: hit test on each game tick, one-cycle REACHED_TARGET pulse, then a new
// target chosen from random candidates (falling back to a raster scan) via occupancy queries.
module target_manager
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 16
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   GAME_TICK,
  input  coord_t HEAD_X,
  input  coord_t HEAD_Y,
  output logic   OCC_REQ,
  output coord_t OCC_X,
  output coord_t OCC_Y,
  input  logic   OCC_VALID,
  input  logic   OCC_HIT,
  output coord_t TARGET_X,
  output coord_t TARGET_Y,
  output logic   TARGET_VALID,
  output logic   REACHED_TARGET,
  output logic   BOARD_FULL
);
  localparam coord_t X_LAST = coord_t'(GRID_W - 1);
  localparam coord_t Y_LAST = coord_t'(GRID_H - 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  tgt_state_t state, nxt;
  logic [2*COORD_W-1:0] rnd;
  logic [TRY_W-1:0] tries;
  coord_t cand_x, cand_y;
  cell_t  occ_cell, scan_ptr, scan_start;
  logic   cand_ok, hit_tick, occ_free, last_try, scan_done;

  target_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (CLK),
    .reset(RESET),
    .en   (1'b1),
    .rnd  (rnd)
  );

  assign cand_x    = rnd[COORD_W-1:0];
  assign cand_y    = rnd[2*COORD_W-1:COORD_W];
  assign cand_ok   = (cand_x <= X_LAST) && (cand_y <= Y_LAST);
  assign hit_tick  = GAME_TICK && (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);
  assign occ_cell  = {OCC_X, OCC_Y};
  // A free cell under the head is still unusable: the snake would eat it immediately.
  assign occ_free  = !OCC_HIT && !((OCC_X == HEAD_X) && (OCC_Y == HEAD_Y));
  assign last_try  = (tries == LAST_TRY);
  assign scan_done = (scan_ptr == scan_start);

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:      if (hit_tick) nxt = ST_GEN;
      ST_GEN:       if (cand_ok) nxt = ST_WAIT_RND;
      ST_WAIT_RND:  if (OCC_VALID) nxt = occ_free ? ST_IDLE : (last_try ? ST_SCAN : ST_GEN);
      ST_SCAN:      nxt = ST_WAIT_SCAN;
      ST_WAIT_SCAN: if (OCC_VALID) nxt = occ_free ? ST_IDLE : (scan_done ? ST_FULL : ST_SCAN);
      ST_FULL:      nxt = ST_FULL;
      default:      nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    TARGET_VALID = (state == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      REACHED_TARGET <= 1'b0;
      OCC_REQ        <= 1'b0;
      OCC_X          <= '0;
      OCC_Y          <= '0;
      TARGET_X       <= coord_t'(GRID_W - 8);
      TARGET_Y       <= coord_t'(GRID_H / 2);
      BOARD_FULL     <= 1'b0;
      tries          <= '0;
      scan_ptr       <= '0;
      scan_start     <= '0;
    end else begin
      REACHED_TARGET <= (state == ST_IDLE) && hit_tick;
      OCC_REQ        <= 1'b0;
      case (state)
        ST_IDLE: if (hit_tick) tries <= '0;
        ST_GEN: begin
          if (cand_ok) begin
            OCC_X   <= cand_x;
            OCC_Y   <= cand_y;
            OCC_REQ <= 1'b1;
          end
        end
        ST_WAIT_RND: begin
          if (OCC_VALID) begin
            if (occ_free) begin
              TARGET_X <= OCC_X;
              TARGET_Y <= OCC_Y;
            end else begin
              // Scan walks every other cell first and re-checks the rejected candidate last.
              tries      <= tries + 1'b1;
              scan_start <= occ_cell;
              scan_ptr   <= raster_next(occ_cell);
            end
          end
        end
        ST_SCAN: begin
          OCC_X   <= scan_ptr.x;
          OCC_Y   <= scan_ptr.y;
          OCC_REQ <= 1'b1;
        end
        ST_WAIT_SCAN: begin
          if (OCC_VALID) begin
            if (occ_free) begin
              TARGET_X <= OCC_X;
              TARGET_Y <= OCC_Y;
            end else if (scan_done) begin
              BOARD_FULL <= 1'b1;
            end else begin
              scan_ptr <= raster_next(scan_ptr);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_target_manager.sv
// Bench for target_manager: occupancy responder with a body map, score stub, per-feature tests.
module tb_target_manager;
  import snake_pkg::*;

  localparam int CELLS = GRID_W * GRID_H;

  logic   CLK = 1'b0;
  logic   RESET = 1'b1;
  logic   GAME_TICK = 1'b0;
  coord_t HEAD_X = '0;
  coord_t HEAD_Y = '0;
  logic   OCC_REQ;
  coord_t OCC_X, OCC_Y;
  logic   OCC_VALID, OCC_HIT;
  coord_t TARGET_X, TARGET_Y;
  logic   TARGET_VALID, REACHED_TARGET, BOARD_FULL;

  int checks = 0;
  int passed = 0;

  bit occ_map [CELLS];
  int resp_lat = 1;
  int resp_mode = 0;
  int force_base = 0;
  int force_n = 0;
  int q_total = 0;
  int qx[$];
  int qy[$];
  int bad_q = 0;
  int last_free_x = -1;
  int last_free_y = -1;
  int score = 0;
  int exp_hits = 0;
  int model_x = 32;
  int model_y = 15;

  target_manager dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .GAME_TICK     (GAME_TICK),
    .HEAD_X        (HEAD_X),
    .HEAD_Y        (HEAD_Y),
    .OCC_REQ       (OCC_REQ),
    .OCC_X         (OCC_X),
    .OCC_Y         (OCC_Y),
    .OCC_VALID     (OCC_VALID),
    .OCC_HIT       (OCC_HIT),
    .TARGET_X      (TARGET_X),
    .TARGET_Y      (TARGET_Y),
    .TARGET_VALID  (TARGET_VALID),
    .REACHED_TARGET(REACHED_TARGET),
    .BOARD_FULL    (BOARD_FULL)
  );

  always #5 CLK = ~CLK;

  // Score counter stub: one count per cycle REACHED_TARGET is high.
  always @(negedge CLK) if (REACHED_TARGET === 1'b1) score++;

  // Snake body store model: answers each query after resp_lat cycles.
  initial begin
    OCC_VALID = 1'b0;
    OCC_HIT   = 1'b0;
    forever begin
      @(negedge CLK);
      if (OCC_REQ === 1'b1) begin
        int x, y;
        bit hit;
        x = int'(OCC_X);
        y = int'(OCC_Y);
        qx.push_back(x);
        qy.push_back(y);
        if (x >= GRID_W || y >= GRID_H) begin
          bad_q++;
          hit = 1'b1;
        end else if (q_total - force_base < force_n) hit = 1'b1;
        else if (resp_mode == 1) hit = 1'b1;
        else hit = occ_map[y*GRID_W + x];
        q_total++;
        repeat (resp_lat - 1) @(negedge CLK);
        if (!hit && !(x == int'(HEAD_X) && y == int'(HEAD_Y))) begin
          last_free_x = x;
          last_free_y = y;
        end
        OCC_HIT   = hit;
        OCC_VALID = 1'b1;
        @(negedge CLK);
        OCC_VALID = 1'b0;
        OCC_HIT   = 1'b0;
      end
    end
  end

  task automatic tick(input int hx, input int hy);
    HEAD_X = coord_t'(hx);
    HEAD_Y = coord_t'(hy);
    GAME_TICK = 1'b1;
    @(negedge CLK);
    GAME_TICK = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    int n = 0;
    while (TARGET_VALID !== 1'b1 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    ok = (TARGET_VALID === 1'b1);
  endtask

  task automatic fill_map(input int pct);
    for (int i = 0; i < CELLS; i++) occ_map[i] = (int'($urandom_range(99)) < pct);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    GAME_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (TARGET_X !== 6'd32 || TARGET_Y !== 6'd15) $display("FAIL reset_target got (%0d,%0d) want (32,15)", TARGET_X, TARGET_Y); else passed++;
    checks++; if (TARGET_VALID !== 1'b1) $display("FAIL reset_valid got %b want 1", TARGET_VALID); else passed++;
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL reset_reached got %b want 0", REACHED_TARGET); else passed++;
    checks++; if (OCC_REQ !== 1'b0) $display("FAIL reset_occ_req got %b want 0", OCC_REQ); else passed++;
    checks++; if (OCC_X !== 6'd0 || OCC_Y !== 6'd0) $display("FAIL reset_occ_xy got (%0d,%0d) want (0,0)", OCC_X, OCC_Y); else passed++;
    checks++; if (BOARD_FULL !== 1'b0) $display("FAIL reset_full got %b want 0", BOARD_FULL); else passed++;
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (TARGET_VALID !== 1'b1 || OCC_REQ !== 1'b0) $display("FAIL idle_quiet valid=%b req=%b want 1/0", TARGET_VALID, OCC_REQ); else passed++;
    model_x = 32;
    model_y = 15;
  endtask

  task automatic test_hit_place();
    bit ok;
    fill_map(0);
    resp_mode = 0;
    resp_lat = 2;
    force_n = 0;
    tick(32, 15);
    exp_hits++;
    checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL hit_pulse got %b want 1", REACHED_TARGET); else passed++;
    checks++; if (TARGET_VALID !== 1'b0) $display("FAIL hit_invalid got %b want 0", TARGET_VALID); else passed++;
    @(negedge CLK);
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL hit_pulse_width got %b want 0", REACHED_TARGET); else passed++;
    wait_valid(200, ok);
    checks++; if (!ok) $display("FAIL place_timeout valid=%b want 1", TARGET_VALID); else passed++;
    checks++; if (int'(TARGET_X) >= GRID_W || int'(TARGET_Y) >= GRID_H) $display("FAIL place_range got (%0d,%0d)", TARGET_X, TARGET_Y); else passed++;
    checks++; if (TARGET_X == HEAD_X && TARGET_Y == HEAD_Y) $display("FAIL place_not_head got (%0d,%0d) head (%0d,%0d)", TARGET_X, TARGET_Y, HEAD_X, HEAD_Y); else passed++;
    checks++; if (TARGET_X !== coord_t'(last_free_x) || TARGET_Y !== coord_t'(last_free_y)) $display("FAIL place_model got (%0d,%0d) want (%0d,%0d)", TARGET_X, TARGET_Y, last_free_x, last_free_y); else passed++;
    model_x = last_free_x;
    model_y = last_free_y;
  endtask

  task automatic test_scan();
    bit ok;
    int base, n, start, head_idx, exp_idx, errs;
    fill_map(50);
    resp_lat = 1;
    force_base = q_total;
    force_n = 16;
    base = qx.size();
    tick(model_x, model_y);
    exp_hits++;
    checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL scan_pulse got %b want 1", REACHED_TARGET); else passed++;
    wait_valid(6000, ok);
    checks++; if (!ok) $display("FAIL scan_timeout valid=%b want 1", TARGET_VALID); else passed++;
    n = qx.size() - base;
    checks++; if (n <= 16) $display("FAIL scan_entered queries=%0d want >16", n); else passed++;
    if (n > 16) begin
      start = qy[base+15] * GRID_W + qx[base+15];
      head_idx = model_y * GRID_W + model_x;
      exp_idx = -1;
      for (int k = 1; k <= CELLS; k++) begin
        int c;
        c = (start + k) % CELLS;
        if (exp_idx < 0 && !occ_map[c] && c != head_idx) exp_idx = c;
      end
      checks++; if (int'(TARGET_Y) * GRID_W + int'(TARGET_X) != exp_idx) $display("FAIL scan_target got (%0d,%0d) want idx %0d", TARGET_X, TARGET_Y, exp_idx); else passed++;
      errs = 0;
      for (int j = 16; j < n; j++)
        if (qy[base+j] * GRID_W + qx[base+j] != (start + j - 15) % CELLS) errs++;
      checks++; if (errs != 0) $display("FAIL scan_order bad_steps=%0d want 0", errs); else passed++;
    end
    force_n = 0;
    model_x = int'(TARGET_X);
    model_y = int'(TARGET_Y);
  endtask

  task automatic test_random(input int rounds);
    bit ok;
    int hx, hy;
    for (int r = 0; r < rounds; r++) begin
      fill_map(int'($urandom_range(40)));
      resp_lat = int'($urandom_range(4, 1));
      if ($urandom_range(2) != 0) begin
        tick(model_x, model_y);
        exp_hits++;
        checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL rnd_hit_pulse r=%0d got %b want 1", r, REACHED_TARGET); else passed++;
        wait_valid(4000, ok);
        checks++; if (!ok) $display("FAIL rnd_timeout r=%0d valid=%b want 1", r, TARGET_VALID); else passed++;
        checks++; if (TARGET_X !== coord_t'(last_free_x) || TARGET_Y !== coord_t'(last_free_y)) $display("FAIL rnd_target r=%0d got (%0d,%0d) want (%0d,%0d)", r, TARGET_X, TARGET_Y, last_free_x, last_free_y); else passed++;
        checks++; if (int'(TARGET_X) >= GRID_W || int'(TARGET_Y) >= GRID_H || occ_map[int'(TARGET_Y)*GRID_W + int'(TARGET_X)]) $display("FAIL rnd_free r=%0d got (%0d,%0d) occupied/out of range", r, TARGET_X, TARGET_Y); else passed++;
        checks++; if (TARGET_X == HEAD_X && TARGET_Y == HEAD_Y) $display("FAIL rnd_not_head r=%0d got (%0d,%0d)", r, TARGET_X, TARGET_Y); else passed++;
        model_x = last_free_x;
        model_y = last_free_y;
      end else begin
        do begin
          hx = int'($urandom_range(GRID_W - 1));
          hy = int'($urandom_range(GRID_H - 1));
        end while (hx == model_x && hy == model_y);
        tick(hx, hy);
        checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL rnd_miss r=%0d got %b want 0", r, REACHED_TARGET); else passed++;
        checks++; if (TARGET_VALID !== 1'b1 || TARGET_X !== coord_t'(model_x) || TARGET_Y !== coord_t'(model_y)) $display("FAIL rnd_keep r=%0d got v=%b (%0d,%0d) want 1 (%0d,%0d)", r, TARGET_VALID, TARGET_X, TARGET_Y, model_x, model_y); else passed++;
      end
    end
  endtask

  task automatic test_gen_tick();
    bit ok;
    fill_map(0);
    resp_lat = 3;
    tick((model_x + 1) % GRID_W, model_y);
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL miss_tick got %b want 0", REACHED_TARGET); else passed++;
    tick(model_x, model_y);
    exp_hits++;
    checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL gen_first_hit got %b want 1", REACHED_TARGET); else passed++;
    tick(model_x, model_y);
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL gen_tick_ignored got %b want 0", REACHED_TARGET); else passed++;
    @(negedge CLK);
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL gen_tick_late got %b want 0", REACHED_TARGET); else passed++;
    wait_valid(2000, ok);
    checks++; if (!ok) $display("FAIL gen_timeout valid=%b want 1", TARGET_VALID); else passed++;
    model_x = last_free_x;
    model_y = last_free_y;
  endtask

  task automatic test_full();
    int base, n;
    resp_mode = 1;
    resp_lat = 1;
    base = qx.size();
    tick(model_x, model_y);
    exp_hits++;
    checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL full_pulse got %b want 1", REACHED_TARGET); else passed++;
    n = 0;
    while (BOARD_FULL !== 1'b1 && n < 10000) begin
      @(negedge CLK);
      n++;
    end
    checks++; if (BOARD_FULL !== 1'b1) $display("FAIL full_flag got %b want 1", BOARD_FULL); else passed++;
    checks++; if (qx.size() - base - 16 != CELLS) $display("FAIL full_scan_count got %0d want %0d", qx.size() - base - 16, CELLS); else passed++;
    checks++; if (TARGET_VALID !== 1'b0) $display("FAIL full_invalid got %b want 0", TARGET_VALID); else passed++;
    tick(int'(TARGET_X), int'(TARGET_Y));
    checks++; if (REACHED_TARGET !== 1'b0) $display("FAIL full_no_pulse got %b want 0", REACHED_TARGET); else passed++;
    repeat (5) @(negedge CLK);
    checks++; if (BOARD_FULL !== 1'b1 || OCC_REQ !== 1'b0 || TARGET_VALID !== 1'b0) $display("FAIL full_sticky full=%b req=%b valid=%b want 1/0/0", BOARD_FULL, OCC_REQ, TARGET_VALID); else passed++;
    resp_mode = 0;
  endtask

  task automatic test_late_valid();
    int n;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    fill_map(0);
    resp_lat = 2;
    @(negedge CLK);
    checks++; if (BOARD_FULL !== 1'b0 || TARGET_VALID !== 1'b1) $display("FAIL full_cleared full=%b valid=%b want 0/1", BOARD_FULL, TARGET_VALID); else passed++;
    tick(32, 15);
    exp_hits++;
    checks++; if (REACHED_TARGET !== 1'b1) $display("FAIL late_pulse got %b want 1", REACHED_TARGET); else passed++;
    n = 0;
    while (OCC_REQ !== 1'b1 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    checks++; if (OCC_REQ !== 1'b1) $display("FAIL late_req_seen got %b want 1", OCC_REQ); else passed++;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (TARGET_X !== 6'd32 || TARGET_Y !== 6'd15 || TARGET_VALID !== 1'b1) $display("FAIL late_target got v=%b (%0d,%0d) want 1 (32,15)", TARGET_VALID, TARGET_X, TARGET_Y); else passed++;
    checks++; if (REACHED_TARGET !== 1'b0 || OCC_REQ !== 1'b0 || BOARD_FULL !== 1'b0) $display("FAIL late_flags got reached=%b req=%b full=%b want 0/0/0", REACHED_TARGET, OCC_REQ, BOARD_FULL); else passed++;
    checks++; if (OCC_X !== 6'd0 || OCC_Y !== 6'd0) $display("FAIL late_occ_xy got (%0d,%0d) want (0,0)", OCC_X, OCC_Y); else passed++;
    repeat (3) @(negedge CLK);
    checks++; if (TARGET_X !== 6'd32 || TARGET_Y !== 6'd15 || TARGET_VALID !== 1'b1) $display("FAIL late_ignored got v=%b (%0d,%0d) want 1 (32,15)", TARGET_VALID, TARGET_X, TARGET_Y); else passed++;
    model_x = 32;
    model_y = 15;
  endtask

  task automatic test_score();
    checks++; if (score != exp_hits) $display("FAIL score_count got %0d want %0d", score, exp_hits); else passed++;
    checks++; if (bad_q != 0) $display("FAIL query_range out_of_grid=%0d want 0", bad_q); else passed++;
  endtask

  initial begin
    test_reset();
    test_hit_place();
    test_scan();
    test_random(20);
    test_gen_tick();
    test_full();
    test_late_valid();
    repeat (4) @(negedge CLK);
    test_score();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end
endmodule
